// File: rtl/fft_pkg.sv
// Shared constants for the 16-point radix-4 FFT datapath.
// A sample is stored as {Re, Im}: Re occupies the upper DW bits, Im the lower DW bits.
package fft_pkg;

  localparam int DW_DEFAULT = 17;
  localparam int FFT_N      = 16;
  localparam int GROUPS     = 4;
  localparam int STRIDE     = FFT_N / GROUPS;

  // Bit offsets of the sample fields, expressed in units of DW
  localparam int SAMPLE_RE_LSB_DW = 1;
  localparam int SAMPLE_IM_LSB_DW = 0;

  typedef logic [1:0] grp_idx_t;

  // Stage-1 rotation code for group g: the butterfly sees {1'b0, g}
  function automatic logic [2:0] rotation_code(input grp_idx_t g);
    return {1'b0, g};
  endfunction

endpackage

// File: rtl/fft_input_loader_if.sv
// Sample-in / group-out bus of the FFT input loader.
// The master modport is the loader side; the slave modport is its environment.
interface fft_input_loader_if
  import fft_pkg::*;
#(
  parameter int DW = DW_DEFAULT
);

  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_re;
  logic [DW-1:0]   in_im;
  logic            out_valid;
  logic            out_ready;
  logic [8*DW-1:0] clac_in;
  logic [2:0]      rotation;
  logic            frame_done;

  modport master (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, clac_in, rotation, frame_done
  );

  modport slave (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, clac_in, rotation, frame_done
  );

endinterface

// File: rtl/fft_bank.sv
// One 16-sample frame buffer with a single write port and a stride-4 group read.
// Contents are intentionally not reset; the full flags in the loader say what is valid.
module fft_bank
  import fft_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic            clk,
  input  logic            we,
  input  logic [3:0]      wr_addr,
  input  logic [2*DW-1:0] wr_data,
  input  grp_idx_t        grp,
  output logic [8*DW-1:0] grp_data
);

  logic [2*DW-1:0] mem_q [FFT_N];
  logic [2*DW-1:0] mem_d [FFT_N];

  // Next contents: write the accepted sample at its natural-order slot
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[wr_addr] = wr_data;
    end else begin
      mem_d[wr_addr] = mem_q[wr_addr];
    end
  end

  // Frame storage register update
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Group read: x[g], x[g+4], x[g+8], x[g+12] packed as {in4, in3, in2, in1}
  always_comb begin
    grp_data = {mem_q[{2'd3, grp}], mem_q[{2'd2, grp}],
                mem_q[{2'd1, grp}], mem_q[{2'd0, grp}]};
  end

endmodule

// File: rtl/fft_input_loader.sv
// FFT input stage: fills two ping-pong frame banks in natural order and drains
// the full one as four stride-4 butterfly groups with their rotation codes.
module fft_input_loader
  import fft_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  fft_input_loader_if.master    bus
);

  logic       wr_bank_q, wr_bank_d;
  logic [3:0] wr_cnt_q,  wr_cnt_d;
  logic       rd_bank_q, rd_bank_d;
  grp_idx_t   g_q,       g_d;
  logic [1:0] full_q,    full_d;
  logic       frame_done_q, frame_done_d;

  logic            in_ready_w;
  logic            out_valid_w;
  logic            in_hs;
  logic            out_hs;
  logic            we0;
  logic            we1;
  logic [2*DW-1:0] wr_data;
  logic [8*DW-1:0] grp_data0;
  logic [8*DW-1:0] grp_data1;

  // Handshake qualifiers; rst masks both sides so nothing is accepted during reset
  always_comb begin
    in_ready_w  = ~rst & ~full_q[wr_bank_q];
    out_valid_w = ~rst &  full_q[rd_bank_q];
    in_hs       = bus.in_valid & in_ready_w;
    out_hs      = out_valid_w & bus.out_ready;
    we0         = in_hs & ~wr_bank_q;
    we1         = in_hs &  wr_bank_q;
    wr_data     = {bus.in_re, bus.in_im};
  end

  fft_bank #(.DW(DW)) u_bank0 (
    .clk      (clk),
    .we       (we0),
    .wr_addr  (wr_cnt_q),
    .wr_data  (wr_data),
    .grp      (g_q),
    .grp_data (grp_data0)
  );

  fft_bank #(.DW(DW)) u_bank1 (
    .clk      (clk),
    .we       (we1),
    .wr_addr  (wr_cnt_q),
    .wr_data  (wr_data),
    .grp      (g_q),
    .grp_data (grp_data1)
  );

  // Pointer and full-flag updates; fill and drain touch different banks so both may act in one cycle
  always_comb begin
    wr_bank_d    = wr_bank_q;
    wr_cnt_d     = wr_cnt_q;
    rd_bank_d    = rd_bank_q;
    g_d          = g_q;
    full_d       = full_q;
    frame_done_d = 1'b0;
    if (in_hs) begin
      wr_cnt_d = wr_cnt_q + 4'd1;
      if (wr_cnt_q == 4'd15) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_bank_d = wr_bank_q;
      end
    end else begin
      wr_cnt_d = wr_cnt_q;
    end
    if (out_hs) begin
      g_d = g_q + 2'd1;
      if (g_q == 2'd3) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        frame_done_d      = 1'b1;
      end else begin
        rd_bank_d = rd_bank_q;
      end
    end else begin
      g_d = g_q;
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q    <= 1'b0;
      wr_cnt_q     <= 4'd0;
      rd_bank_q    <= 1'b0;
      g_q          <= 2'd0;
      full_q       <= 2'b00;
      frame_done_q <= 1'b0;
    end else begin
      wr_bank_q    <= wr_bank_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_bank_q    <= rd_bank_d;
      g_q          <= g_d;
      full_q       <= full_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Output drive: group word straight from bank storage, forced to zero when not valid
  always_comb begin
    bus.in_ready   = in_ready_w;
    bus.out_valid  = out_valid_w;
    bus.frame_done = frame_done_q;
    if (out_valid_w) begin
      if (rd_bank_q) begin
        bus.clac_in = grp_data1;
      end else begin
        bus.clac_in = grp_data0;
      end
      bus.rotation = rotation_code(g_q);
    end else begin
      bus.clac_in  = {(8*DW){1'b0}};
      bus.rotation = 3'b000;
    end
  end

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed and randomized checks of the FFT input loader against a queue-based
// reference: accepted samples queue up in order, and the head frame is read stride-4.
module tb_fft_input_loader;

  localparam int DW = 17;

  logic clk;
  logic rst;

  fft_input_loader_if #(.DW(DW)) bus ();

  fft_input_loader #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference state
  logic [2*DW-1:0] sq[$];
  int   mg        = 0;
  logic fd_exp    = 1'b0;
  int   dut_ohs   = 0;
  int   ready_low = 0;
  int   pushed    = 0;

  task automatic chk(input string tag, input logic [8*DW-1:0] obs, input logic [8*DW-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, compare outputs with the reference, advance the reference
  task automatic tick(input logic v, input logic [DW-1:0] re, input logic [DW-1:0] im, input logic ordy);
    logic [8*DW-1:0] exp_clac;
    logic            er;
    logic            ev;
    @(negedge clk);
    rst           = 1'b0;
    bus.in_valid  = v;
    bus.in_re     = re;
    bus.in_im     = im;
    bus.out_ready = ordy;
    #1;
    er       = (sq.size() < 32);
    ev       = (sq.size() >= 16);
    exp_clac = '0;
    if (ev) exp_clac = {sq[mg+12], sq[mg+8], sq[mg+4], sq[mg]};
    chk("in_ready",   bus.in_ready,   er);
    chk("out_valid",  bus.out_valid,  ev);
    chk("clac_in",    bus.clac_in,    exp_clac);
    chk("rotation",   bus.rotation,   ev ? mg : 0);
    chk("frame_done", bus.frame_done, fd_exp);
    if (bus.out_valid === 1'b1 && ordy) dut_ohs++;
    if (bus.in_ready !== 1'b1) ready_low++;
    fd_exp = 1'b0;
    if (ev && ordy) begin
      if (mg == 3) begin
        for (int i = 0; i < 16; i++) void'(sq.pop_front());
        fd_exp = 1'b1;
        mg     = 0;
      end else begin
        mg = mg + 1;
      end
    end
    if (er && v) begin
      sq.push_back({re, im});
      pushed++;
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst           = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_re     = 17'h1ABCD;
      bus.in_im     = 17'h01234;
      bus.out_ready = 1'b1;
      #1;
      chk("rst_in_ready",  bus.in_ready,  1'b0);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_clac_in",   bus.clac_in,   '0);
    end
    sq.delete();
    mg     = 0;
    fd_exp = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_re     = '0;
    bus.in_im     = '0;
    bus.out_ready = 1'b0;

    // Reset with samples offered
    do_reset(2);

    // Single frame: x[k] = (k, -k)
    for (int k = 0; k < 16; k++) tick(1'b1, DW'(k), DW'(-k), 1'b1);
    tick(1'b0, 17'd0, 17'd0, 1'b1);
    chk("sf_valid_rise", bus.out_valid, 1'b1);
    chk("sf_g0_in1", bus.clac_in[33:0], {17'h00000, 17'h00000});
    chk("sf_g0_in2", bus.clac_in[67:34], {17'h00004, 17'h1FFFC});
    tick(1'b0, 17'd0, 17'd0, 1'b1);
    chk("sf_g1_in1", bus.clac_in[33:0], {17'h00001, 17'h1FFFF});
    chk("sf_g1_in4", bus.clac_in[135:102], {17'h0000D, 17'h1FFF3});
    chk("sf_g1_rot", bus.rotation, 3'b001);
    tick(1'b0, 17'd0, 17'd0, 1'b1);
    tick(1'b0, 17'd0, 17'd0, 1'b1);
    chk("sf_g3_rot", bus.rotation, 3'b011);
    tick(1'b0, 17'd0, 17'd0, 1'b1);
    chk("sf_frame_done", bus.frame_done, 1'b1);
    chk("sf_empty", bus.out_valid, 1'b0);
    tick(1'b0, 17'd0, 17'd0, 1'b1);
    chk("sf_done_pulse", bus.frame_done, 1'b0);

    // Backpressure: two frames stored, input blocked, then ordered drain
    for (int k = 0; k < 32; k++) tick(1'b1, DW'(k + 32), DW'(k), 1'b0);
    tick(1'b1, 17'h15555, 17'h0AAAA, 1'b0);
    chk("bp_in_ready_low", bus.in_ready, 1'b0);
    chk("bp_hold_rot", bus.rotation, 3'b000);
    chk("bp_hold_in1", bus.clac_in[33:0], {17'd32, 17'd0});
    tick(1'b1, 17'h15555, 17'h0AAAA, 1'b0);
    chk("bp_hold_in4", bus.clac_in[135:102], {17'd44, 17'd12});
    for (int i = 0; i < 4; i++) tick(1'b0, 17'd0, 17'd0, 1'b1);
    tick(1'b0, 17'd0, 17'd0, 1'b1);
    chk("bp_in_ready_back", bus.in_ready, 1'b1);
    chk("bp_frame1_in1", bus.clac_in[33:0], {17'd48, 17'd16});
    for (int i = 0; i < 4; i++) tick(1'b0, 17'd0, 17'd0, 1'b1);

    // Streaming: three back-to-back frames
    dut_ohs   = 0;
    ready_low = 0;
    for (int k = 0; k < 48; k++) tick(1'b1, DW'(k + 1000), DW'(~k), 1'b1);
    chk("st_no_stall", ready_low, 0);
    for (int i = 0; i < 8; i++) tick(1'b0, 17'd0, 17'd0, 1'b1);
    chk("st_groups", dut_ohs, 12);

    // Reset mid-frame: partial frame discarded
    for (int k = 0; k < 7; k++) tick(1'b1, DW'(k + 200), DW'(k), 1'b1);
    do_reset(1);
    for (int k = 0; k < 16; k++) tick(1'b1, DW'(k + 300), DW'(k + 5), 1'b1);
    tick(1'b0, 17'd0, 17'd0, 1'b1);
    chk("mr_fresh_in1", bus.clac_in[33:0], {17'd300, 17'd5});
    for (int i = 0; i < 4; i++) tick(1'b0, 17'd0, 17'd0, 1'b1);

    // Random gaps over 50 frames
    pushed = 0;
    for (int c = 0; c < 6000 && pushed < 800; c++) begin
      tick($urandom_range(0, 3) != 0, DW'($urandom), DW'($urandom), $urandom_range(0, 3) != 0);
    end
    chk("rnd_all_accepted", pushed, 800);
    for (int c = 0; c < 40 && sq.size() != 0; c++) tick(1'b0, 17'd0, 17'd0, 1'b1);
    tick(1'b0, 17'd0, 17'd0, 1'b1);
    chk("rnd_drained", bus.out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
